clkgen_multi: RTL and testbench

- Multi-channel programmable clock-enable/square-wave generator driven from the 50 MHz system clock clkin.
- Each of NCH channels divides clkin by a runtime-programmable half-period, producing a square wave and a one-cycle rising-edge tick.
- Serves the timer, UART-baud and display-scan consumers in place of fixed per-frequency divider instances.
- Configuration arrives over a simple single-cycle write bus from the CPU/MMIO glue.

---
 rtl/clkgen_pkg.sv | 22 ++
 rtl/clkgen_channel.sv | 67 ++++++
 rtl/clkgen_multi.sv | 63 ++++++
 tb/tb_clkgen_multi.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared helpers for clkgen_multi; CLKGEN_DUTY_EN adds the low/high register-select address bit.
package clkgen_pkg;
  localparam int EW = 64;
  localparam logic REG_LO = 1'b0;
  localparam logic REG_HI = 1'b1;
  function automatic int def_hp(input int clk_freq, input int def_freq);
    return clk_freq / 2 / def_freq;
  endfunction
  function automatic logic [EW-1:0] eff(input logic [EW-1:0] x);
    return (x == '0) ? EW'(1) : x;
  endfunction
  function automatic int ch_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction
  function automatic int aw_of(input int nch);
`ifdef CLKGEN_DUTY_EN
    return ch_bits(nch) + 1;
`else
    return ch_bits(nch);
`endif
  endfunction
endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one divider channel; new timing takes effect only at the 1->0 edge or while held.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int CW = 32,
  parameter logic [CW-1:0] DEF_HP = CW'(5)
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          en,
  input  logic          we_lo,
`ifdef CLKGEN_DUTY_EN
  input  logic          we_hi,
  output logic [CW-1:0] hi_act,
`endif
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] lo_act,
  output logic          clkout,
  output logic          tick
);
  logic [CW-1:0] cnt, cnt_nx, len, lo_pend;
  logic pend, wrap, fall, load, wr;
`ifdef CLKGEN_DUTY_EN
  logic [CW-1:0] hi_pend;
  assign wr = we_lo || we_hi;
  assign len = CW'(eff(EW'(clkout ? hi_act : lo_act)));
  always_ff @(posedge clkin) begin
    if (rst) begin
      hi_act <= DEF_HP;
      hi_pend <= DEF_HP;
    end else begin
      if (load) hi_act <= hi_pend;
      if (we_hi) hi_pend <= wdata;
    end
  end
`else
  assign wr = we_lo;
  assign len = CW'(eff(EW'(lo_act)));
`endif
  assign cnt_nx = cnt + CW'(1);
  assign wrap = cnt_nx >= len;
  assign fall = en && wrap && clkout;
  assign load = pend && (fall || !en);
  // a write on a load edge lands after the transfer and stays pending
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt <= '0;
      clkout <= 1'b0;
      tick <= 1'b0;
      lo_act <= DEF_HP;
      lo_pend <= DEF_HP;
      pend <= 1'b0;
    end else begin
      if (en) begin
        cnt <= wrap ? '0 : cnt_nx;
        clkout <= clkout ^ wrap;
      end
      tick <= en && wrap && !clkout;
      if (load) begin
        lo_act <= lo_pend;
        pend <= 1'b0;
      end
      if (we_lo) lo_pend <= wdata;
      if (wr) pend <= 1'b1;
    end
  end
endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH programmable square-wave/tick generators with a write bus and readback.
// Define CLKGEN_DUTY_EN for separate low/high times selected by the cfg_addr MSB.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW = 32,
  parameter int CLK_FREQ = 50000000,
  parameter int DEF_FREQ = 1000,
  localparam int AW = aw_of(NCH)
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  output logic [CW-1:0]  cfg_rdata,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] tick
);
  localparam int CB = ch_bits(NCH);
  localparam logic [CW-1:0] DEF_HP = CW'(def_hp(CLK_FREQ, DEF_FREQ));
  logic [CB-1:0] ch;
  logic [CW-1:0] lo_rd [2**CB];
  assign ch = cfg_addr[CB-1:0];
`ifdef CLKGEN_DUTY_EN
  logic sel;
  logic [CW-1:0] hi_rd [2**CB];
  assign sel = cfg_addr[AW-1];
  assign cfg_rdata = (sel == REG_HI) ? hi_rd[ch] : lo_rd[ch];
`else
  assign cfg_rdata = lo_rd[ch];
`endif
  // unpopulated address slots read zero and never match a write
  for (genvar i = 0; i < 2**CB; i++) begin : g_ch
    if (i < NCH) begin : g_on
      logic hit;
      assign hit = cfg_we && ch == CB'(i);
      clkgen_channel #(.CW(CW), .DEF_HP(DEF_HP)) u_ch (
        .clkin,
        .rst,
        .en(en[i]),
`ifdef CLKGEN_DUTY_EN
        .we_lo(hit && sel == REG_LO),
        .we_hi(hit && sel == REG_HI),
        .hi_act(hi_rd[i]),
`else
        .we_lo(hit),
`endif
        .wdata(cfg_data),
        .lo_act(lo_rd[i]),
        .clkout(clkout[i]),
        .tick(tick[i])
      );
    end else begin : g_off
      assign lo_rd[i] = '0;
`ifdef CLKGEN_DUTY_EN
      assign hi_rd[i] = '0;
`endif
    end
  end
endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed table, corner sequences and random stimulus against a phase-length model.
module tb_clkgen_multi;
  localparam int NCH = 4;
  localparam int CW = 32;
  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [CW-1:0] cfg_rdata;
  logic [NCH-1:0] clkout, tick;
  int checks = 0, errors = 0;

  clkgen_multi #(.NCH(NCH), .CW(CW), .CLK_FREQ(100), .DEF_FREQ(10)) dut (
    .clkin(clkin), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_rdata(cfg_rdata), .clkout(clkout), .tick(tick)
  );

  always #5 clkin = ~clkin;

  int m_el [NCH];
  bit m_lvl [NCH], m_tick [NCH], m_pf [NCH];
  int unsigned m_act [NCH], m_pv [NCH];

  function automatic int unsigned eff(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_edge();
    bit fall;
    for (int i = 0; i < NCH; i++) begin
      fall = 1'b0;
      if (rst) begin
        m_el[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_act[i] = 5; m_pv[i] = 5; m_pf[i] = 0;
      end else begin
        m_tick[i] = 0;
        if (en[i]) begin
          if (m_el[i] + 1 >= int'(eff(m_act[i]))) begin
            m_el[i] = 0;
            m_lvl[i] = !m_lvl[i];
            fall = !m_lvl[i];
            m_tick[i] = m_lvl[i];
          end else m_el[i]++;
        end
        if (m_pf[i] && (fall || !en[i])) begin m_act[i] = m_pv[i]; m_pf[i] = 0; end
        if (cfg_we && int'(cfg_addr) == i) begin m_pv[i] = cfg_data; m_pf[i] = 1; end
      end
    end
  endtask

  function automatic logic [NCH-1:0] mvec(input bit want_tick);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = want_tick ? m_tick[i] : m_lvl[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    chk("clkout", CW'(clkout), CW'(mvec(0)));
    chk("tick", CW'(tick), CW'(mvec(1)));
    chk("rdata", cfg_rdata, m_act[cfg_addr]);
  endtask

  task automatic run_until(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clkout[ch] !== lvl && n < 100);
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
  } vec_t;
  vec_t tbl [24];

  initial begin
    int n;
    logic lvl;
    for (int k = 0; k < 24; k++) begin
      tbl[k].en = 4'b0001;
      tbl[k].exp_clk = {3'b000, ((k + 1) / 5) % 2 == 1};
      tbl[k].exp_tick = {3'b000, (k + 1) % 10 == 5};
    end
    step();
    rst = 1'b0;
    chk("rst_clkout", CW'(clkout), '0);
    chk("rst_tick", CW'(tick), '0);
    chk("rst_rdata0", cfg_rdata, 5);
    cfg_addr = 2'd3;
    #1 chk("rst_rdata3", cfg_rdata, 5);
    cfg_addr = 2'd0;
    for (int k = 0; k < 24; k++) begin
      en = tbl[k].en;
      step();
      chk("tbl_clk", CW'(clkout), CW'(tbl[k].exp_clk));
      chk("tbl_tick", CW'(tick), CW'(tbl[k].exp_tick));
    end
    // ch1 reprogrammed two cycles into its high phase
    en = 4'b0011;
    cfg_addr = 2'd1;
    run_until(1, 1'b1, n);
    step();
    cfg_we = 1'b1; cfg_data = 3;
    step();
    cfg_we = 1'b0;
    chk("ch1_rdata_old", cfg_rdata, 5);
    run_until(1, 1'b0, n);
    chk("ch1_high_rest", n, 3);
    chk("ch1_rdata_new", cfg_rdata, 3);
    run_until(1, 1'b1, n);
    chk("ch1_low3", n, 3);
    run_until(1, 1'b0, n);
    chk("ch1_high3", n, 3);
    // ch2 held at cnt=3, then a write during a hold applies at once
    en[2] = 1'b1;
    repeat (3) step();
    en[2] = 1'b0;
    lvl = clkout[2];
    repeat (7) step();
    chk("ch2_frozen", CW'(clkout[2]), CW'(lvl));
    en[2] = 1'b1;
    run_until(2, !lvl, n);
    chk("ch2_resume", n, 2);
    en[2] = 1'b0;
    cfg_addr = 2'd2; cfg_we = 1'b1; cfg_data = 7;
    step();
    cfg_we = 1'b0;
    step();
    chk("ch2_hold_load", cfg_rdata, 7);
    en[2] = 1'b1;
    lvl = clkout[2];
    run_until(2, !lvl, n);
    chk("ch2_new_len", n, 7);
    // ch3 with hp=0 behaves as hp=1
    cfg_addr = 2'd3; cfg_we = 1'b1; cfg_data = 0;
    step();
    cfg_we = 1'b0;
    step();
    en[3] = 1'b1;
    run_until(3, 1'b1, n);
    chk("ch3_rise", n, 1);
    chk("ch3_tick", CW'(tick[3]), 1);
    run_until(3, 1'b0, n);
    chk("ch3_fall", n, 1);
    chk("ch3_notick", CW'(tick[3]), 0);
    // reset discards a pending write on ch0
    en = 4'b0001;
    cfg_addr = 2'd0; cfg_we = 1'b1; cfg_data = 8;
    step();
    cfg_we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_clkout", CW'(clkout), '0);
    chk("rst2_rdata", cfg_rdata, 5);
    run_until(0, 1'b1, n);
    chk("rst2_low", n, 5);
    run_until(0, 1'b0, n);
    chk("rst2_high", n, 5);
    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      en = NCH'($urandom);
      cfg_addr = 2'($urandom);
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_data = $urandom_range(0, 7);
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
